// File: rtl/clkmon_pkg.sv
// Shared types and default timing constants for the slow-clock monitor family.
// The defaults assume a 50 MHz system clock.
package clkmon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED,
        LOST
    } clkmon_state_t;

    localparam int unsigned SYS_CLK_HZ     = 50_000_000;
    localparam int unsigned PERIOD_1HZ     = SYS_CLK_HZ;
    localparam int unsigned PERIOD_0P5HZ   = 2 * SYS_CLK_HZ;
    localparam int unsigned DEF_TOLERANCE  = 1000;
    localparam int unsigned DEF_TIMEOUT    = 2 * PERIOD_0P5HZ;
    localparam int unsigned DEF_LOCK_COUNT = 2;
    localparam int unsigned DEF_CNT_W      = 28;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser with rising-edge detect for an asynchronous level input.
// rise is a decode of flops (glitch-free); rise_q is the same pulse one cycle later.
module sync_edge_detect (
    input  logic clock_in,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic rise_q
);

    logic s1;
    logic s2;
    logic prev;

    assign rise = s2 & ~prev;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            prev   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1     <= async_in;
            s2     <= s1;
            prev   <= s2;
            rise_q <= rise;
        end
    end

endmodule

// File: rtl/slow_clock_monitor.sv
// Measures the period of a divider-generated slow clock, emits synchronous tick
// enables on its rising edges and tracks lock / loss of the expected period.
module slow_clock_monitor
    import clkmon_pkg::*;
#(
    parameter int unsigned EXPECTED_PERIOD = PERIOD_0P5HZ,
    parameter int unsigned TOLERANCE       = DEF_TOLERANCE,
    parameter int unsigned TIMEOUT         = DEF_TIMEOUT,
    parameter int unsigned LOCK_COUNT      = DEF_LOCK_COUNT,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             slow_clk_in,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam int unsigned GC_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic signed [CNT_W:0] EXP_S = $signed((CNT_W + 1)'(EXPECTED_PERIOD));
    localparam logic [63:0] TO_LAST = 64'(TIMEOUT) - 64'd1;

    clkmon_state_t    state;
    clkmon_state_t    state_next;
    logic [GC_W-1:0]  good_count;
    logic [GC_W-1:0]  gc_inc;
    logic [GC_W-1:0]  gc_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cand;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]   abs_diff;
    logic             rise;
    logic             rise_q;
    logic             good;
    logic             timeout_hit;
    logic             pv_next;

    sync_edge_detect u_sync (
        .clock_in (clock_in),
        .reset    (reset),
        .async_in (slow_clk_in),
        .rise     (rise),
        .rise_q   (rise_q)
    );

    // State and period registers act on the flop-decoded rise so that tick,
    // period, period_valid, locked and lost all change in the same cycle.
    assign tick = rise_q;

    assign cand        = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign diff        = $signed({1'b0, cand}) - EXP_S;
    assign abs_diff    = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign good        = ({{(63 - CNT_W){1'b0}}, abs_diff} <= 64'(TOLERANCE));
    assign timeout_hit = ({{(64 - CNT_W){1'b0}}, cnt} == TO_LAST);
    assign gc_inc      = (&good_count) ? good_count : good_count + GC_W'(1);

    always_comb begin
        state_next = state;
        gc_next    = good_count;
        pv_next    = 1'b0;
        if (rise) begin
            case (state)
                IDLE: begin
                    state_next = MEASURE;
                    gc_next    = '0;
                end
                MEASURE: begin
                    pv_next = 1'b1;
                    if (good) begin
                        gc_next = gc_inc;
                        if (32'(gc_inc) >= LOCK_COUNT) state_next = LOCKED;
                    end else begin
                        gc_next = '0;
                    end
                end
                LOCKED: begin
                    pv_next = 1'b1;
                    if (!good) state_next = LOST;
                end
                LOST: begin
                    state_next = MEASURE;
                    gc_next    = '0;
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout_hit && state != LOST) begin
            state_next = LOST;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            good_count   <= '0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            state        <= state_next;
            good_count   <= gc_next;
            cnt          <= rise ? '0 : cand;
            period_valid <= pv_next;
            if (pv_next) period <= cand;
            locked       <= (state_next == LOCKED);
            lost         <= (state_next == LOST);
        end
    end

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor with a small parameterisation
// (period 8, tolerance 1, timeout 20, lock after 2 good periods).
module tb_slow_clock_monitor;

    logic       clock_in = 1'b0;
    logic       reset;
    logic       slow_clk_in;
    logic       tick;
    logic [5:0] period;
    logic       period_valid;
    logic       locked;
    logic       lost;

    int errors = 0;
    int checks = 0;

    logic       obs_early;
    logic       obs_tick;
    logic       obs_pv;
    logic [5:0] obs_per;
    logic       obs_lk;
    logic       obs_ls;
    logic       obs_after;

    slow_clock_monitor #(
        .EXPECTED_PERIOD (8),
        .TOLERANCE       (1),
        .TIMEOUT         (20),
        .LOCK_COUNT      (2),
        .CNT_W           (6)
    ) dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .slow_clk_in  (slow_clk_in),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    always #5 clock_in = ~clock_in;

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    // One slow-clock cycle: h steps high (h >= 4), l steps low; observes the tick cycle.
    task automatic pulse(input int h, input int l);
        slow_clk_in = 1'b1;
        step();
        step();
        obs_early = tick;
        step();
        obs_tick = tick;
        obs_pv   = period_valid;
        obs_per  = period;
        obs_lk   = locked;
        obs_ls   = lost;
        step();
        obs_after = tick | period_valid;
        repeat (h - 4) step();
        slow_clk_in = 1'b0;
        repeat (l) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        slow_clk_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            slow_clk_in = ~slow_clk_in;
            checks++; if ({tick, period_valid, locked, lost} !== 4'b0000) begin errors++; $display("FAIL reset_outs[%0d]: got %b expected 0000", i, {tick, period_valid, locked, lost}); end
        end
        checks++; if (period !== 6'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period); end
        step();
        reset = 1'b0;
        slow_clk_in = 1'b0;
        step();
        step();
        pulse(4, 4);
        checks++; if (obs_early !== 1'b0) begin errors++; $display("FAIL first_tick_early: got %b expected 0", obs_early); end
        checks++; if (obs_tick !== 1'b1) begin errors++; $display("FAIL first_tick: got %b expected 1", obs_tick); end
        checks++; if (obs_pv !== 1'b0) begin errors++; $display("FAIL first_pv: got %b expected 0", obs_pv); end
        checks++; if (obs_per !== 6'd0) begin errors++; $display("FAIL first_period: got %0d expected 0", obs_per); end
        checks++; if ({obs_lk, obs_ls} !== 2'b00) begin errors++; $display("FAIL first_status: got %b expected 00", {obs_lk, obs_ls}); end
        checks++; if (obs_after !== 1'b0) begin errors++; $display("FAIL first_one_cycle: got %b expected 0", obs_after); end
    endtask

    task automatic test_lock(input string tag);
        pulse(4, 4);
        checks++; if ({obs_tick, obs_pv} !== 2'b11) begin errors++; $display("FAIL %s_t2_pulse: got %b expected 11", tag, {obs_tick, obs_pv}); end
        checks++; if (obs_per !== 6'd8) begin errors++; $display("FAIL %s_t2_period: got %0d expected 8", tag, obs_per); end
        checks++; if ({obs_lk, obs_ls} !== 2'b00) begin errors++; $display("FAIL %s_t2_status: got %b expected 00", tag, {obs_lk, obs_ls}); end
        checks++; if (obs_after !== 1'b0) begin errors++; $display("FAIL %s_t2_one_cycle: got %b expected 0", tag, obs_after); end
        pulse(4, 4);
        checks++; if (obs_per !== 6'd8) begin errors++; $display("FAIL %s_t3_period: got %0d expected 8", tag, obs_per); end
        checks++; if ({obs_lk, obs_ls} !== 2'b10) begin errors++; $display("FAIL %s_t3_status: got %b expected 10", tag, {obs_lk, obs_ls}); end
    endtask

    task automatic test_jitter();
        int lows[4] = '{5, 3, 5, 4};
        int exp_per[4] = '{8, 9, 7, 9};
        for (int i = 0; i < 4; i++) begin
            pulse(4, lows[i]);
            checks++; if (obs_per !== 6'(exp_per[i])) begin errors++; $display("FAIL jitter_period[%0d]: got %0d expected %0d", i, obs_per, exp_per[i]); end
            checks++; if ({obs_pv, obs_lk, obs_ls} !== 3'b110) begin errors++; $display("FAIL jitter_status[%0d]: got %b expected 110", i, {obs_pv, obs_lk, obs_ls}); end
        end
    endtask

    task automatic test_lose_relock();
        pulse(5, 5);
        checks++; if ({obs_lk, obs_per} !== {1'b1, 6'd8}) begin errors++; $display("FAIL pre_bad_lock: got %b/%0d expected 1/8", obs_lk, obs_per); end
        pulse(4, 4);
        checks++; if (obs_per !== 6'd10) begin errors++; $display("FAIL bad_period: got %0d expected 10", obs_per); end
        checks++; if ({obs_pv, obs_lk, obs_ls} !== 3'b101) begin errors++; $display("FAIL bad_status: got %b expected 101", {obs_pv, obs_lk, obs_ls}); end
        pulse(4, 4);
        checks++; if ({obs_tick, obs_pv, obs_lk, obs_ls} !== 4'b1000) begin errors++; $display("FAIL leave_lost: got %b expected 1000", {obs_tick, obs_pv, obs_lk, obs_ls}); end
        checks++; if (obs_per !== 6'd10) begin errors++; $display("FAIL leave_lost_hold: got %0d expected 10", obs_per); end
        pulse(4, 4);
        checks++; if ({obs_pv, obs_lk, obs_ls} !== 3'b100) begin errors++; $display("FAIL remeasure_1: got %b expected 100", {obs_pv, obs_lk, obs_ls}); end
        pulse(4, 4);
        checks++; if ({obs_pv, obs_lk, obs_ls} !== 3'b110) begin errors++; $display("FAIL relock: got %b expected 110", {obs_pv, obs_lk, obs_ls}); end
    endtask

    task automatic test_timeout();
        slow_clk_in = 1'b1;
        repeat (3) step();
        checks++; if ({tick, locked, period} !== {2'b11, 6'd8}) begin errors++; $display("FAIL to_last_tick: got %b%b/%0d expected 11/8", tick, locked, period); end
        step();
        slow_clk_in = 1'b0;
        repeat (18) step();
        checks++; if ({locked, lost} !== 2'b10) begin errors++; $display("FAIL to_before: got %b expected 10", {locked, lost}); end
        step();
        checks++; if ({locked, lost} !== 2'b01) begin errors++; $display("FAIL to_fire: got %b expected 01", {locked, lost}); end
        repeat (30) step();
        checks++; if ({locked, lost, tick} !== 3'b010) begin errors++; $display("FAIL to_hold: got %b expected 010", {locked, lost, tick}); end
        // Leave LOST, then land the next rise on the cycle the timeout would fire.
        slow_clk_in = 1'b1;
        repeat (3) step();
        checks++; if ({tick, period_valid, locked, lost} !== 4'b1000) begin errors++; $display("FAIL race_enter: got %b expected 1000", {tick, period_valid, locked, lost}); end
        step();
        slow_clk_in = 1'b0;
        repeat (16) step();
        slow_clk_in = 1'b1;
        repeat (2) step();
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL race_pre: got %b expected 0", lost); end
        step();
        checks++; if ({tick, period_valid, lost} !== 3'b110) begin errors++; $display("FAIL race_rise_wins: got %b expected 110", {tick, period_valid, lost}); end
        checks++; if (period !== 6'd20) begin errors++; $display("FAIL race_period: got %0d expected 20", period); end
        step();
        slow_clk_in = 1'b0;
        repeat (4) step();
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL race_after: got %b expected 0", lost); end
    endtask

    task automatic test_async_reset();
        pulse(4, 4);
        pulse(4, 4);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ar_prelock: got %b expected 1", locked); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if ({locked, lost, period} !== {2'b00, 6'd0}) begin errors++; $display("FAIL ar_immediate: got %b%b/%0d expected 00/0", locked, lost, period); end
        step();
        step();
        reset = 1'b0;
        step();
        step();
        pulse(4, 4);
        checks++; if ({obs_tick, obs_pv, obs_lk} !== 3'b100) begin errors++; $display("FAIL ar_first_tick: got %b expected 100", {obs_tick, obs_pv, obs_lk}); end
        test_lock("ar");
    endtask

    initial begin
        test_reset();
        test_lock("lock");
        test_jitter();
        test_lose_relock();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
